// File: rtl/weight_stream_mem.sv
// weight_stream_mem
//   Signed weight store for the classifier datapath. Weights are streamed in
//   through a valid/ready load port, and an auto-incrementing pointer places
//   each one. A base/length read job then streams the words to the MAC array.
//   The read path is a two-stage pipeline (registered array read, then the
//   output register), so holding rd_ready_i high gives one beat per cycle.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   clr_i                 synchronous clear (array contents kept)
//   wr_valid_i/wr_data_i  load word, accepted when wr_ready_o is high
//   wr_ready_o            high in IDLE/LOAD
//   load_done_o           high once DEPTH words have been loaded
//   rd_start_i            read job request, sampled with rd_base_i/rd_len_i
//   rd_ready_i            consumer ready
//   rd_valid_o/rd_data_o  read beat (rd_data_o is zero while not valid)
//   rd_last_o             final beat of a job
//   finish_o              one-cycle pulse after the final beat is accepted
//   busy_o                high in LOAD and STREAM
module weight_stream_mem #(
    parameter int DW    = 9,
    parameter int DEPTH = 30,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          wr_valid_i,
    input  logic [DW-1:0] wr_data_i,
    output logic          wr_ready_o,
    output logic          load_done_o,
    input  logic          rd_start_i,
    input  logic [AW-1:0] rd_base_i,
    input  logic [AW:0]   rd_len_i,
    input  logic          rd_ready_i,
    output logic          rd_valid_o,
    output logic [DW-1:0] rd_data_o,
    output logic          rd_last_o,
    output logic          finish_o,
    output logic          busy_o
);

    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LAST_PTR  = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   ONE_W     = (AW+1)'(1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_READY  = 2'd2,
        S_STREAM = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic          load_done_q, load_done_d;
    logic          wr_ready_q, wr_ready_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW:0]   rem_q, rem_d;
    logic          s1_valid_q, s1_valid_d;
    logic          s1_last_q, s1_last_d;
    logic [DW-1:0] s1_data_q;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          finish_q, finish_d;

    logic wr_acc_s, wr_last_s, start_ok_s, out_adv_s, s1_adv_s, issue_s, beat_done_s;

    // clr suppresses the write so that nothing lands in the array on a clear cycle
    assign wr_acc_s    = wr_valid_i & wr_ready_q & ~clr_i;
    assign wr_last_s   = (wr_ptr_q == LAST_PTR);
    assign start_ok_s  = (state_q == S_READY) & rd_start_i & (rd_len_i != {(AW+1){1'b0}})
                       & (rd_len_i <= DEPTH_W) & ({1'b0, rd_base_i} < DEPTH_W);
    // Each stage may advance when it is empty or its content moves on this cycle
    assign out_adv_s   = ~out_valid_q | rd_ready_i;
    assign s1_adv_s    = ~s1_valid_q | out_adv_s;
    assign issue_s     = (state_q == S_STREAM) & (rem_q != {(AW+1){1'b0}}) & s1_adv_s & ~clr_i;
    assign beat_done_s = out_valid_q & rd_ready_i & out_last_q;

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (wr_acc_s) begin
                    state_d = wr_last_s ? S_READY : S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (wr_acc_s && wr_last_s) begin
                    state_d = S_READY;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_READY: begin
                if (start_ok_s) begin
                    state_d = S_STREAM;
                end else begin
                    state_d = S_READY;
                end
            end
            S_STREAM: begin
                if (beat_done_s) begin
                    state_d = S_READY;
                end else begin
                    state_d = S_STREAM;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (clr_i) begin
            state_d = S_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // Datapath next-state: load pointer, read address/count, read pipeline, flags
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        load_done_d = load_done_q;
        rd_addr_d   = rd_addr_q;
        rem_d       = rem_q;
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        finish_d    = beat_done_s;

        if (wr_acc_s) begin
            wr_ptr_d    = wr_ptr_q + ONE_W;
            load_done_d = load_done_q | wr_last_s;
        end else begin
            wr_ptr_d    = wr_ptr_q;
        end

        if (start_ok_s) begin
            rd_addr_d = rd_base_i;
            rem_d     = rd_len_i;
        end else if (issue_s) begin
            rd_addr_d = (rd_addr_q == LAST_ADDR) ? {AW{1'b0}} : rd_addr_q + AW'(1);
            rem_d     = rem_q - ONE_W;
        end else begin
            rem_d     = rem_q;
        end

        if (s1_adv_s) begin
            s1_valid_d = issue_s;
            s1_last_d  = issue_s & (rem_q == ONE_W);
        end else begin
            s1_valid_d = s1_valid_q;
        end

        // Output data is zeroed whenever no beat is being presented
        if (out_adv_s) begin
            out_valid_d = s1_valid_q;
            out_last_d  = s1_valid_q & s1_last_q;
            out_data_d  = s1_valid_q ? s1_data_q : {DW{1'b0}};
        end else begin
            out_valid_d = out_valid_q;
        end

        if (clr_i) begin
            wr_ptr_d    = {(AW+1){1'b0}};
            load_done_d = 1'b0;
            rd_addr_d   = {AW{1'b0}};
            rem_d       = {(AW+1){1'b0}};
            s1_valid_d  = 1'b0;
            s1_last_d   = 1'b0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = {DW{1'b0}};
            finish_d    = 1'b0;
        end else begin
            finish_d    = finish_d;
        end
    end

    // Status outputs registered from the next state so they line up with it
    always_comb begin
        wr_ready_d = (state_d == S_IDLE) | (state_d == S_LOAD);
        busy_d     = (state_d == S_LOAD) | (state_d == S_STREAM);
    end

    // State and control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= {(AW+1){1'b0}};
            load_done_q <= 1'b0;
            wr_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            rd_addr_q   <= {AW{1'b0}};
            rem_q       <= {(AW+1){1'b0}};
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= {DW{1'b0}};
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            load_done_q <= load_done_d;
            wr_ready_q  <= wr_ready_d;
            busy_q      <= busy_d;
            rd_addr_q   <= rd_addr_d;
            rem_q       <= rem_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            finish_q    <= finish_d;
        end
    end

    // Weight array write and registered read (no reset: contents are don't-care)
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
        if (issue_s) begin
            s1_data_q <= mem_q[rd_addr_q];
        end
    end

    assign wr_ready_o  = wr_ready_q;
    assign load_done_o = load_done_q;
    assign busy_o      = busy_q;
    assign rd_valid_o  = out_valid_q;
    assign rd_data_o   = out_data_q;
    assign rd_last_o   = out_last_q;
    assign finish_o    = finish_q;

endmodule
